noc_switch_alloc: RTL and testbench
===================================

Name: noc_switch_alloc

Overview:
- Packet-level switch allocator that drives a crossbar's `dest`/`dest_en` controls.
- Per output port, round-robin arbitration among inputs requesting that port.
- The winner keeps the output until its tail flit transfers, so packets are never interleaved.
- Sits between the input buffers and the crossbar in each router, replacing per-cycle rotating priority with wormhole-style locking.

Parameters:
- PORTS, 2, number of input and output ports; must be ≥2.
- IDLE_LIMIT, 8, cycles without a request from the owner before forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req[PORTS]  input  1 each  input i holds a flit for transfer.
- req_dest[PORTS]  input  $clog2(PORTS) each  requested output of input i; stable while req[i]=1.
- req_last[PORTS]  input  1 each  current flit of input i is the packet tail.
- out_ready[PORTS]  input  1 each  output o can accept a flit (no backpressure).
- dest[PORTS]  output  $clog2(PORTS) each  crossbar destination for input i.
- dest_en[PORTS]  output  1 each  input i transfers a flit this cycle (grant/pop).
- out_busy[PORTS]  output  1 each  output o is locked to an owner.
- out_owner[PORTS]  output  $clog2(PORTS) each  current owner of output o (valid when out_busy[o]=1).

Behaviour:
- Reset (async, immediate): every output 0; all output FSMs in IDLE; rr_ptr[o]=PORTS-1, so input 0 has top priority first; idle counters 0.
- Per output o, FSM with two states, IDLE and LOCKED.
- IDLE:
  - candidates = inputs i with req[i]=1 and req_dest[i]=o.
  - Winner = first candidate scanning rr_ptr[o]+1, +2, … modulo PORTS.
  - If a winner exists: at the clock edge, owner[o]<=winner, state<=LOCKED.
  - No flit transfers in IDLE; allocation costs 1 cycle.
- LOCKED:
  - Combinational: dest[owner]=o and dest_en[owner]=req[owner] & out_ready[o].
  - Inputs with no owned output drive dest=0 and dest_en=0.
- Transfer with tail (dest_en[owner]=1 and req_last[owner]=1):
  - next state IDLE; rr_ptr[o]<=owner.
  - The next packet is granted at the earliest 2 cycles after the tail, giving 1 bubble.
- Transfer without tail: stay LOCKED, with 1 flit per cycle sustained throughput.
- out_ready[o]=0: dest_en[owner]=0 and state unchanged; backpressure never releases the lock.
- Latency: req rising in cycle N to a free output gives dest_en in cycle N+1 (if out_ready).
- Single-flit packet (req_last=1 on the first flit): LOCKED for exactly 1 transfer cycle, then IDLE.
- Ownership:
  - An input requests one output at a time, so it owns at most one output.
  - Several outputs may be LOCKED simultaneously to different owners.
  - Non-conflicting packets flow in parallel.
- Simultaneous requests: exactly one winner per output per allocation; losers keep req high and wait.
- Fairness: with N contenders, each waits at most N-1 packets.
- Protocol check (simulation assertion): while LOCKED, req_dest[owner]==o whenever req[owner]=1.
- Reset mid-packet: all locks dropped immediately; dest_en=0 while rst=1 and on the first cycle after release (FSM in IDLE).
- out_busy[o]=(state==LOCKED); out_owner[o]=owner[o] when busy, else 0.

Optional Feature:
- Macro: NOC_ALLOC_TIMEOUT_EN.
- Defined:
  - Per-output counter, width $clog2(IDLE_LIMIT+1).
  - Counter increments each LOCKED cycle with req[owner]=0; cleared on any cycle with req[owner]=1 and on entering LOCKED.
  - On reaching IDLE_LIMIT: forced release to IDLE, rr_ptr[o]<=owner; the incomplete packet is dropped from allocation.
- Not defined: no counter logic; a LOCKED output releases only on a tail transfer or reset.

Test Plan:
- Reset/basic: assert rst, then check all outputs are 0. Release rst; req[0]=1, req_dest[0]=1, req_last[0]=1, out_ready=all 1 at cycle 0. Expect dest_en[0]=1, dest[0]=1 at cycle 1 only; out_busy[1]=1 at cycle 1, 0 at cycle 2.
- Contention/RR: inputs 0 and 1 both target output 0 with 3-flit packets. Expect input 0 granted for 3 transfer cycles, then 1 bubble, then input 1 for 3 cycles. Repeating both packets gives the order 0,1,0,1.
- Parallel: input 0 targets output 1 and input 1 targets output 0 in the same cycle. Both dest_en are 1 from the next cycle; both outputs are busy.
- Backpressure: input 0 is locked on output 1 mid-packet; out_ready[1]=0 for 4 cycles. Expect dest_en[0]=0 and out_busy[1]=1 throughout; transfer resumes the cycle out_ready returns.
- Reset mid-packet: rst pulses during the second flit of a 4-flit packet. Outputs go to 0 asynchronously; re-arbitration starts from input 0 priority.
- Timeout (macro defined, IDLE_LIMIT=8): owner drops req after 1 non-tail flit. out_busy clears after exactly 8 idle cycles. Without the macro, out_busy stays 1 for 50 cycles.

Source files
------------

// File: rtl/noc_switch_alloc_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
// master = input-buffer/crossbar side, slave = allocator.
interface noc_switch_alloc_if #(
    parameter int PORTS = 2
);
    localparam int IDX_W = $clog2(PORTS);

    logic [PORTS-1:0]            req;
    logic [PORTS-1:0][IDX_W-1:0] req_dest;
    logic [PORTS-1:0]            req_last;
    logic [PORTS-1:0]            out_ready;
    logic [PORTS-1:0][IDX_W-1:0] dest;
    logic [PORTS-1:0]            dest_en;
    logic [PORTS-1:0]            out_busy;
    logic [PORTS-1:0][IDX_W-1:0] out_owner;

    modport master (
        output req, req_dest, req_last, out_ready,
        input  dest, dest_en, out_busy, out_owner
    );

    modport slave (
        input  req, req_dest, req_last, out_ready,
        output dest, dest_en, out_busy, out_owner
    );
endinterface

// File: rtl/noc_switch_alloc.sv
// Packet-level switch allocator: per-output round-robin with wormhole locking until tail.
// Optional owner-idle timeout release is enabled by defining NOC_ALLOC_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | output free; arbitrates among inputs requesting it (no transfer)
// LOCKED | output owned by one input until its tail flit transfers
module noc_switch_alloc #(
    parameter int PORTS      = 2,
    parameter int IDLE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    noc_switch_alloc_if.slave bus
);
    localparam int IDX_W = $clog2(PORTS);

    if (PORTS < 2 || IDLE_LIMIT < 1) begin : g_param_check
        $error("noc_switch_alloc: PORTS must be >= 2 and IDLE_LIMIT >= 1");
    end

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q  [PORTS];
    state_t           state_d  [PORTS];
    logic [IDX_W-1:0] owner_q  [PORTS];
    logic [IDX_W-1:0] owner_d  [PORTS];
    logic [IDX_W-1:0] rr_ptr_q [PORTS];
    logic [IDX_W-1:0] rr_ptr_d [PORTS];

    logic [PORTS-1:0]            dest_en;
    logic [PORTS-1:0][IDX_W-1:0] dest;

`ifdef NOC_ALLOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(IDLE_LIMIT + 1);
    logic [CNT_W-1:0] idle_cnt_q [PORTS];
    logic [CNT_W-1:0] idle_cnt_d [PORTS];
`endif

    // Each input owns at most one output, so no two locked outputs share an owner.
    always_comb begin
        dest    = '0;
        dest_en = '0;
        for (int o = 0; o < PORTS; o++) begin
            if (state_q[o] == LOCKED) begin
                dest[owner_q[o]]    = IDX_W'(o);
                dest_en[owner_q[o]] = bus.req[owner_q[o]] & bus.out_ready[o];
            end
        end
    end

    always_comb begin
        logic             found;
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int o = 0; o < PORTS; o++) begin
            state_d[o]  = state_q[o];
            owner_d[o]  = owner_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
`ifdef NOC_ALLOC_TIMEOUT_EN
            idle_cnt_d[o] = '0;
`endif
            if (state_q[o] == IDLE) begin
                found = 1'b0;
                // Scan starts just after the last owner, so it has lowest priority.
                for (int k = 1; k <= PORTS; k++) begin
                    cand     = (int'(rr_ptr_q[o]) + k) % PORTS;
                    cand_idx = IDX_W'(cand);
                    if (!found && bus.req[cand_idx] && bus.req_dest[cand_idx] == IDX_W'(o)) begin
                        found      = 1'b1;
                        owner_d[o] = cand_idx;
                        state_d[o] = LOCKED;
                    end
                end
            end else begin
                if (dest_en[owner_q[o]] && bus.req_last[owner_q[o]]) begin
                    state_d[o]  = IDLE;
                    rr_ptr_d[o] = owner_q[o];
                end
`ifdef NOC_ALLOC_TIMEOUT_EN
                if (!bus.req[owner_q[o]]) begin
                    if (idle_cnt_q[o] == CNT_W'(IDLE_LIMIT - 1)) begin
                        state_d[o]  = IDLE;
                        rr_ptr_d[o] = owner_q[o];
                    end else begin
                        idle_cnt_d[o] = idle_cnt_q[o] + CNT_W'(1);
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < PORTS; o++) begin
                state_q[o]  <= IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= IDX_W'(PORTS - 1);
`ifdef NOC_ALLOC_TIMEOUT_EN
                idle_cnt_q[o] <= '0;
`endif
            end
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
`ifdef NOC_ALLOC_TIMEOUT_EN
                idle_cnt_q[o] <= idle_cnt_d[o];
`endif
            end
        end
    end

    always_comb begin
        bus.out_busy  = '0;
        bus.out_owner = '0;
        for (int o = 0; o < PORTS; o++) begin
            bus.out_busy[o]  = (state_q[o] == LOCKED);
            bus.out_owner[o] = (state_q[o] == LOCKED) ? owner_q[o] : '0;
        end
    end

    assign bus.dest    = dest;
    assign bus.dest_en = dest_en;

`ifndef SYNTHESIS
    // An owner must keep pointing at the output it holds while it requests.
    always @(posedge clk) begin
        for (int o = 0; o < PORTS; o++) begin
            if (!rst && state_q[o] == LOCKED && bus.req[owner_q[o]]) begin
                assert (bus.req_dest[owner_q[o]] == IDX_W'(o));
            end
        end
    end
`endif
endmodule

// File: tb/tb_noc_switch_alloc.sv
// Self-checking bench for noc_switch_alloc: packet-level reference model, directed
// scenarios with literal expectations, then randomized packet traffic.
module tb_noc_switch_alloc;
    localparam int P   = 3;
    localparam int W   = $clog2(P);
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_switch_alloc_if #(.PORTS(P)) bus ();

    noc_switch_alloc #(.PORTS(P), .IDLE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: per output busy flag, owner, last winner, idle run length
    int m_busy  [P];
    int m_owner [P];
    int m_last  [P];
    int m_idle  [P];

    // traffic sources: one packet in flight per input
    int src_act  [P];
    int src_dst  [P];
    int src_rem  [P];
    int src_gap  [P];
    int src_hold [P];

    logic [P-1:0]        last_en;
    logic [P-1:0]        s_en;
    logic [P-1:0][W-1:0] s_dest;
    logic [P-1:0]        s_busy;
    logic [P-1:0][W-1:0] s_owner;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            m_busy[o]  = 0;
            m_owner[o] = 0;
            m_last[o]  = P - 1;
            m_idle[o]  = 0;
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < P; i++) begin
            src_act[i]  = 0;
            src_dst[i]  = 0;
            src_rem[i]  = 0;
            src_gap[i]  = 0;
            src_hold[i] = 0;
        end
    endtask

    task automatic src_start(input int i, input int dst, input int len);
        src_act[i] = 1;
        src_dst[i] = dst;
        src_rem[i] = len;
    endtask

    // Compare on the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        logic [P-1:0]        e_en;
        logic [P-1:0][W-1:0] e_dest;
        logic [P-1:0]        e_busy;
        logic [P-1:0][W-1:0] e_owner;
        int best;
        int bd;
        int d;
        int ow;
        @(negedge clk);
        e_en    = '0;
        e_dest  = '0;
        e_busy  = '0;
        e_owner = '0;
        if (!rst) begin
            for (int o = 0; o < P; o++) begin
                if (m_busy[o] != 0) begin
                    e_busy[o]           = 1'b1;
                    e_owner[o]          = W'(m_owner[o]);
                    e_dest[m_owner[o]]  = W'(o);
                    e_en[m_owner[o]]    = bus.req[m_owner[o]] & bus.out_ready[o];
                end
            end
        end
        s_en    = bus.dest_en;
        s_dest  = bus.dest;
        s_busy  = bus.out_busy;
        s_owner = bus.out_owner;
        chk("dest_en",   int'(s_en),    int'(e_en));
        chk("dest",      int'(s_dest),  int'(e_dest));
        chk("out_busy",  int'(s_busy),  int'(e_busy));
        chk("out_owner", int'(s_owner), int'(e_owner));
        last_en = e_en;
        if (rst) begin
            model_reset();
        end else begin
            for (int o = 0; o < P; o++) begin
                if (m_busy[o] != 0) begin
                    ow = m_owner[o];
                    if (e_en[ow] && bus.req_last[ow]) begin
                        m_busy[o] = 0;
                        m_last[o] = ow;
                        m_idle[o] = 0;
                    end
`ifdef NOC_ALLOC_TIMEOUT_EN
                    else if (bus.req[ow]) begin
                        m_idle[o] = 0;
                    end else begin
                        m_idle[o]++;
                        if (m_idle[o] == LIM) begin
                            m_busy[o] = 0;
                            m_last[o] = ow;
                            m_idle[o] = 0;
                        end
                    end
`endif
                end else begin
                    best = -1;
                    bd   = P;
                    for (int i = 0; i < P; i++) begin
                        if (bus.req[i] && int'(bus.req_dest[i]) == o) begin
                            d = (i - m_last[o] - 1 + 2 * P) % P;
                            if (d < bd) begin
                                bd   = d;
                                best = i;
                            end
                        end
                    end
                    if (best >= 0) begin
                        m_busy[o]  = 1;
                        m_owner[o] = best;
                        m_idle[o]  = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sources(input logic [P-1:0] rdy, input bit rnd);
        for (int i = 0; i < P; i++) begin
            if (src_gap[i] != 0) begin
                src_gap[i] = 0;
            end else if (rnd && src_act[i] == 0 && $urandom_range(3) == 0) begin
                src_start(i, int'($urandom_range(P - 1)), 1 + int'($urandom_range(3)));
            end
            bus.req[i]       = (src_act[i] != 0) && (src_hold[i] == 0) && !(rnd && $urandom_range(7) == 0);
            bus.req_dest[i]  = W'(src_dst[i]);
            bus.req_last[i]  = (src_act[i] != 0) && (src_rem[i] == 1);
            bus.out_ready[i] = rnd ? ($urandom_range(3) != 0) : rdy[i];
        end
    endtask

    task automatic update_sources();
        for (int i = 0; i < P; i++) begin
            if (src_act[i] != 0 && last_en[i]) begin
                src_rem[i]--;
                if (src_rem[i] == 0) begin
                    src_act[i] = 0;
                    src_gap[i] = 1;
                end
            end
        end
    endtask

    task automatic run(input int n, input logic [P-1:0] rdy, input bit rnd);
        for (int c = 0; c < n; c++) begin
            drive_sources(rdy, rnd);
            tick();
            update_sources();
        end
    endtask

    localparam logic [P-1:0] ALL = '1;

    initial begin
        logic [P-1:0] exp_trace [9];
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_dest  = '0;
        bus.req_last  = '0;
        bus.out_ready = '0;
        last_en       = '0;
        model_reset();
        src_clear();
        exp_trace = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};

        // reset state
        @(posedge clk);
        #1;
        chk("rst_busy",    int'(bus.out_busy),  0);
        chk("rst_dest_en", int'(bus.dest_en),   0);
        chk("rst_dest",    int'(bus.dest),      0);
        chk("rst_owner",   int'(bus.out_owner), 0);
        tick();
        rst = 1'b0;

        // single-flit packet: input 0 -> output 1
        src_start(0, 1, 1);
        run(1, ALL, 0);
        chk("basic_c0_en",   int'(s_en),   0);
        chk("basic_c0_busy", int'(s_busy), 0);
        run(1, ALL, 0);
        chk("basic_c1_en",    int'(s_en),    1);
        chk("basic_c1_dest",  int'(s_dest),  1);
        chk("basic_c1_busy",  int'(s_busy),  2);
        chk("basic_c1_owner", int'(s_owner), 0);
        run(1, ALL, 0);
        chk("basic_c2_en",   int'(s_en),   0);
        chk("basic_c2_busy", int'(s_busy), 0);

        // contention on output 0, two rounds: order 0,1,0,1
        for (int r = 0; r < 2; r++) begin
            src_start(0, 0, 3);
            src_start(1, 0, 3);
            for (int c = 0; c < 9; c++) begin
                run(1, ALL, 0);
                chk($sformatf("rr_r%0d_c%0d", r, c), int'(s_en), int'(exp_trace[c]));
            end
        end

        // parallel non-conflicting packets
        src_start(0, 1, 2);
        src_start(1, 0, 2);
        run(1, ALL, 0);
        chk("par_c0_en", int'(s_en), 0);
        run(1, ALL, 0);
        chk("par_c1_en",    int'(s_en),    3);
        chk("par_c1_busy",  int'(s_busy),  3);
        chk("par_c1_dest",  int'(s_dest),  1);
        chk("par_c1_owner", int'(s_owner), 1);
        run(2, ALL, 0);

        // backpressure mid-packet
        src_start(0, 1, 6);
        run(3, ALL, 0);
        for (int c = 0; c < 4; c++) begin
            run(1, 3'b101, 0);
            chk($sformatf("bp_stall%0d_en", c),   int'(s_en),   0);
            chk($sformatf("bp_stall%0d_busy", c), int'(s_busy), 2);
        end
        run(1, ALL, 0);
        chk("bp_resume_en", int'(s_en), 1);
        run(4, ALL, 0);

        // reset mid-packet: move output 2 priority away from input 0 first
        src_start(0, 2, 1);
        run(3, ALL, 0);
        src_start(0, 2, 4);
        run(2, ALL, 0);
        drive_sources(ALL, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en",    int'(bus.dest_en),   0);
        chk("arst_busy",  int'(bus.out_busy),  0);
        chk("arst_dest",  int'(bus.dest),      0);
        chk("arst_owner", int'(bus.out_owner), 0);
        model_reset();
        src_clear();
        tick();
        rst = 1'b0;
        src_start(1, 2, 1);
        src_start(0, 2, 1);
        run(1, ALL, 0);
        chk("arst_rel_en", int'(s_en), 0);
        run(1, ALL, 0);
        chk("arst_prio_en", int'(s_en), 1);
        run(3, ALL, 0);

        // owner stops requesting after one non-tail flit
        src_start(0, 1, 5);
        run(2, ALL, 0);
        src_hold[0] = 1;
`ifdef NOC_ALLOC_TIMEOUT_EN
        for (int c = 0; c < LIM; c++) begin
            run(1, ALL, 0);
            chk($sformatf("to_hold%0d_busy", c), int'(s_busy), 2);
        end
        run(1, ALL, 0);
        chk("to_release_busy", int'(s_busy), 0);
`else
        for (int c = 0; c < 50; c++) begin
            run(1, ALL, 0);
            chk($sformatf("lock_hold%0d_busy", c), int'(s_busy), 2);
        end
`endif
        src_hold[0] = 0;
        run(12, ALL, 0);

        // randomized traffic
        src_clear();
        run(3000, ALL, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
